// File: rtl/cnn_net_ctrl_pkg.sv
// Shared definitions for the CNN network sequencer: element width, layer codes
// understood by cnn_layer, and the controller state encodings.
package cnn_net_ctrl_pkg;

    localparam int unsigned DATA_LEN = 16;

    localparam logic [3:0] LIDL   = 4'd0;
    localparam logic [3:0] CONV1  = 4'd1;
    localparam logic [3:0] AFFINE = 4'd15;

    typedef enum logic [2:0] {
        NIDL = 3'd0,
        NLOD = 3'd1,
        NGRD = 3'd2,
        NWAT = 3'd3,
        NSTR = 3'd4,
        NDON = 3'd5
    } net_state_e;

    // Conv passes count up from CONV1; the pass after the last conv is the affine.
    function automatic logic [3:0] layer_code(input logic [3:0] idx, input logic [3:0] num_conv);
        if (idx < num_conv) begin
            return 4'(CONV1 + idx);
        end
        return AFFINE;
    endfunction

endpackage

// File: rtl/cnn_net_ctrl_relu_vec.sv
// Per-element signed clamp at zero across a flattened feature map.
// Only instantiated when CNN_RELU_EN is defined.
module relu_vec #(
    parameter int unsigned FM_W   = 6144,
    parameter int unsigned ELEM_W = 16
) (
    input  logic [FM_W-1:0] d,
    output logic [FM_W-1:0] q
);

    localparam int unsigned NUM_ELEM = FM_W / ELEM_W;

    for (genvar i = 0; i < NUM_ELEM; i++) begin : g_elem
        assign q[i*ELEM_W +: ELEM_W] = d[i*ELEM_W + ELEM_W - 1] ? '0 : d[i*ELEM_W +: ELEM_W];
    end

endmodule

// File: rtl/cnn_net_ctrl.sv
// Network sequencer driving cnn_layer through NUM_CONV conv passes and one affine pass.
// Optional build macro CNN_RELU_EN clamps negative conv outputs before reuse.
module cnn_net_ctrl
    import cnn_net_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CONV = 3,
    parameter int unsigned FM_W     = 32 * 12 * DATA_LEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [FM_W-1:0] d_in,
    output logic            busy,
    output logic            done,
    output logic [FM_W-1:0] result,
    output logic            layer_load,
    output logic [3:0]      layer_cs,
    output logic [FM_W-1:0] layer_d,
    input  logic            layer_valid,
    input  logic [FM_W-1:0] layer_q
);

    localparam logic [3:0] NUM_CONV_L = 4'(NUM_CONV);

    net_state_e      state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [FM_W-1:0] feat_q, feat_d;
    logic [FM_W-1:0] result_q, result_d;
    logic [FM_W-1:0] store_val;
    logic            is_affine;

`ifdef CNN_RELU_EN
    relu_vec #(
        .FM_W   (FM_W),
        .ELEM_W (DATA_LEN)
    ) u_relu (
        .d (layer_q),
        .q (store_val)
    );
`else
    assign store_val = layer_q;
`endif

    assign is_affine = (idx_q == NUM_CONV_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= NIDL;
            idx_q    <= '0;
            feat_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            feat_q   <= feat_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        feat_d     = feat_q;
        result_d   = result_q;
        busy       = 1'b1;
        done       = 1'b0;
        layer_load = 1'b0;
        layer_cs   = layer_code(idx_q, NUM_CONV_L);

        case (state_q)
            NIDL: begin
                busy     = 1'b0;
                layer_cs = LIDL;
                if (start) begin
                    feat_d  = d_in;
                    idx_d   = '0;
                    state_d = NLOD;
                end
            end
            NLOD: begin
                layer_load = 1'b1;
                state_d    = NGRD;
            end
            // layer_valid may still be high from the previous pass's FINI here
            NGRD: state_d = NWAT;
            NWAT: begin
                if (layer_valid) begin
                    state_d = NSTR;
                end
            end
            NSTR: begin
                if (is_affine) begin
                    result_d = layer_q;
                    state_d  = NDON;
                end else begin
                    feat_d  = store_val;
                    idx_d   = idx_q + 4'd1;
                    state_d = NLOD;
                end
            end
            NDON: begin
                done    = 1'b1;
                state_d = NIDL;
            end
            default: state_d = NIDL;
        endcase
    end

    assign layer_d = feat_q;
    assign result  = result_q;

endmodule

// File: tb/tb_cnn_net_ctrl.sv
// Directed bench for cnn_net_ctrl with a behavioural cnn_layer model and a
// scoreboard of expected layer codes, layer inputs and final results.
module tb_cnn_net_ctrl;

    localparam int unsigned DL       = 16;
    localparam int unsigned FM_W     = 32 * 12 * DL;
    localparam int unsigned NE       = FM_W / DL;
    localparam int unsigned NCONV    = 3;
    localparam int          NLAT     = 5;
    localparam int          DONE_CYC = 1 + 4 * (3 + NLAT);
    localparam logic [3:0]  C_LIDL   = 4'd0;
    localparam logic [3:0]  C_CONV1  = 4'd1;
    localparam logic [3:0]  C_AFFINE = 4'd15;
`ifdef CNN_RELU_EN
    localparam logic [15:0] RELU_E0 = 16'h0000;
`else
    localparam logic [15:0] RELU_E0 = 16'hFFF0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [FM_W-1:0] d_in;
    logic            busy, done, layer_load, layer_valid;
    logic [FM_W-1:0] result, layer_d, layer_q;
    logic [3:0]      layer_cs;

    int n_cmp = 0;
    int n_err = 0;
    int model_mode = 0;
    int mcnt;

    logic [3:0]      exp_cs_q[$];
    logic [FM_W-1:0] exp_d_q[$];
    logic [FM_W-1:0] exp_res_q[$];

    cnn_net_ctrl #(
        .NUM_CONV (NCONV),
        .FM_W     (FM_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .d_in        (d_in),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .layer_load  (layer_load),
        .layer_cs    (layer_cs),
        .layer_d     (layer_d),
        .layer_valid (layer_valid),
        .layer_q     (layer_q)
    );

    always #5 clk = ~clk;

    function automatic logic [FM_W-1:0] layer_fn(input logic [FM_W-1:0] d, input logic [3:0] cs,
                                                 input int mode);
        logic [FM_W-1:0] q;
        logic [15:0]     e;
        q = '0;
        for (int i = 0; i < NE; i++) begin
            e = d[i*DL +: DL];
            if (mode == 1) begin
                if (i == 0) e = 16'hFFF0;
                else if (i == 1) e = 16'h0010;
            end else begin
                e = e + e + {12'd0, cs} + 16'(i);
            end
            q[i*DL +: DL] = e;
        end
        return q;
    endfunction

    function automatic logic [FM_W-1:0] relu_fm(input logic [FM_W-1:0] d);
        logic [FM_W-1:0] q;
        q = d;
        for (int i = 0; i < NE; i++) begin
            if (d[i*DL + DL - 1]) q[i*DL +: DL] = '0;
        end
        return q;
    endfunction

    // Layer model: valid drops after GUARD, rises NLAT edges after the load edge,
    // then stays high until the next pass so the stale level reaches GUARD.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_valid <= 1'b0;
            layer_q     <= '0;
            mcnt        <= 0;
        end else if (layer_load) begin
            mcnt <= 1;
        end else if (mcnt != 0) begin
            if (mcnt == 1) layer_valid <= 1'b0;
            if (mcnt == NLAT) begin
                layer_valid <= 1'b1;
                layer_q     <= layer_fn(layer_d, layer_cs, model_mode);
                mcnt        <= 0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [FM_W-1:0] obs,
                           input logic [FM_W-1:0] exp);
        int k;
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            k = 0;
            for (int i = NE - 1; i >= 0; i--) begin
                if (obs[i*DL +: DL] !== exp[i*DL +: DL]) k = i;
            end
            $error("FAIL %s: element %0d got 0x%0h expected 0x%0h", tag, k,
                   obs[k*DL +: DL], exp[k*DL +: DL]);
        end
    endtask

    task automatic run_pass(input logic [FM_W-1:0] din, input int mode, input bit pulse10,
                            input int abort_load);
        logic [FM_W-1:0] d, q, res_exp;
        logic [3:0]      cs;
        int              cyc, loads, last_load;
        bit              got_done;

        d = din;
        for (int l = 0; l <= NCONV; l++) begin
            cs = (l < NCONV) ? 4'(C_CONV1 + l) : C_AFFINE;
            exp_cs_q.push_back(cs);
            exp_d_q.push_back(d);
            q = layer_fn(d, cs, mode);
`ifdef CNN_RELU_EN
            if (l < NCONV) d = relu_fm(q);
`else
            if (l < NCONV) d = q;
`endif
            else exp_res_q.push_back(q);
        end
        model_mode = mode;
        res_exp    = '0;

        start = 1'b1;
        d_in  = din;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_rise", 64'(busy), 64'd1);

        cyc       = 1;
        loads     = 0;
        last_load = 0;
        got_done  = 0;
        while (cyc <= 200) begin
            if (layer_load) begin
                loads++;
                if (loads > 1) chk("pass_len", 64'(cyc - last_load), 64'(3 + NLAT));
                last_load = cyc;
                if (exp_cs_q.size() > 0) begin
                    chk("layer_cs", 64'(layer_cs), 64'(exp_cs_q.pop_front()));
                    chk_vec("layer_d", layer_d, exp_d_q.pop_front());
                end else begin
                    chk("extra_load", 64'(loads), 64'(NCONV + 1));
                end
                if (mode == 1 && loads == 2) begin
                    chk("relu_e0", 64'(layer_d[15:0]), 64'(RELU_E0));
                    chk("relu_e1", 64'(layer_d[31:16]), 64'h0010);
                end
            end
            if (abort_load != 0 && loads == abort_load && cyc == last_load + 3) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_done", 64'(done), 64'd0);
                chk("rst_load", 64'(layer_load), 64'd0);
                chk("rst_cs", 64'(layer_cs), 64'(C_LIDL));
                chk_vec("rst_layer_d", layer_d, '0);
                chk_vec("rst_result", result, '0);
                exp_cs_q.delete();
                exp_d_q.delete();
                exp_res_q.delete();
                return;
            end
            start = (pulse10 && cyc == 10);
            if (pulse10 && cyc == 10) d_in = ~din;
            if (done) begin
                got_done = 1;
                chk("done_cyc", 64'(cyc), 64'(DONE_CYC));
                chk("load_cnt", 64'(loads), 64'(NCONV + 1));
                if (exp_res_q.size() > 0) begin
                    res_exp = exp_res_q.pop_front();
                    chk_vec("result", result, res_exp);
                end
                if (mode == 1) chk("result_e0", 64'(result[15:0]), 64'hFFF0);
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        if (!got_done) chk("done_timeout", 64'(cyc), 64'(DONE_CYC));

        @(posedge clk);
        #1;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_cs", 64'(layer_cs), 64'(C_LIDL));
        @(posedge clk);
        #1;
        chk("idle_busy2", 64'(busy), 64'd0);
        chk("idle_load", 64'(layer_load), 64'd0);
        chk_vec("result_hold", result, res_exp);
    endtask

    initial begin
        logic [FM_W-1:0] ones;
        logic [FM_W-1:0] ramp;
        for (int i = 0; i < NE; i++) begin
            ones[i*DL +: DL] = 16'h0001;
            ramp[i*DL +: DL] = 16'(i * 3 + 2);
        end

        rst_n = 1'b0;
        start = 1'b0;
        d_in  = '0;
        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_load", 64'(layer_load), 64'd0);
        chk("reset_cs", 64'(layer_cs), 64'(C_LIDL));
        chk_vec("reset_layer_d", layer_d, '0);
        chk_vec("reset_result", result, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain run, then a run whose first GUARD sees the stale valid level.
        run_pass(ones, 0, 1'b0, 0);
        run_pass(ramp, 0, 1'b0, 0);

        // Second start mid-run must be dropped.
        run_pass(ones, 0, 1'b1, 0);

        // Reset while waiting on pass 2, then a clean restart from CONV1.
        run_pass(ramp, 0, 1'b0, 2);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_pass(ones, 0, 1'b0, 0);

        // Negative conv element, clamped only when CNN_RELU_EN is built in.
        run_pass(ones, 1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
